// File: rtl/nmi_arbiter_if.sv
// CPU bus signals seen by the NMI arbiter: memory/IO request, read strobe,
// opcode-fetch (M1) and the 16-bit address. All strobes are active-high.
interface cpu_bus;
    logic        memreq;
    logic        ioreq;
    logic        rd;
    logic        m1;
    logic [15:0] a;

    modport arb  (input  memreq, ioreq, rd, m1, a);
    modport host (output memreq, ioreq, rd, m1, a);
endinterface

// File: rtl/nmi_arbiter.sv
// nmi_arbiter: shares the Z80 NMI line between magic (0), pause (1) and
// divmmc (2) requesters with rotating priority. Assertions are aligned to the
// frame strobe, n_nmi is held low until the 0x0066 vector fetch, and a
// frame-counted holdoff follows each service. A status byte is readable on
// the I/O bus.
module nmi_arbiter #(
    parameter logic [15:0] TIMEOUT        = 16'd50000,
    parameter logic [7:0]  HOLDOFF_FRAMES = 8'd2,
    parameter logic [15:0] STATUS_PORT    = 16'h00F7
) (
    input  logic       clk28,
    input  logic       rst,
    cpu_bus.arb        bus,
    input  logic       n_int,
    input  logic       n_int_next,
    input  logic [2:0] req,
    input  logic       done,
    output logic       n_nmi,
    output logic [2:0] grant,
    output logic       busy,
    output logic [7:0] d_out,
    output logic       d_out_active
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_ASSERT  = 3'd2,
        S_SERVICE = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    // Round-robin pick: first pending source at or after 'start', wrapping mod 3.
    function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] start);
        logic [1:0] i1;
        logic [1:0] i2;
        i1 = (start == 2'd2) ? 2'd0 : start + 2'd1;
        i2 = (i1 == 2'd2) ? 2'd0 : i1 + 2'd1;
        if (pend[start])
            return start;
        else if (pend[i1])
            return i1;
        else
            return i2;
    endfunction

    // Pointer to the source following the winner, mod 3.
    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Request synchroniser and edge-detect registers
    logic [2:0]  req_s1;
    logic [2:0]  req_s2;
    logic [2:0]  req_d;
    logic [2:0]  req_edge;

    // Arbitration and FSM state
    state_t      state, state_n;
    logic [2:0]  pending, pending_n;
    logic [1:0]  ptr, ptr_n;
    logic [2:0]  grant_n;
    logic        n_nmi_n;
    logic [15:0] tcount, tcount_n;
    logic [7:0]  fcount, fcount_n;
    logic        err, err_n;
    logic        err_set;
    logic [2:0]  clr_mask;
    logic [2:0]  set_back;
    logic [1:0]  win;
    logic [2:0]  win_oh;

    // Bus decode and status path
    logic        fs;
    logic        fetch;
    logic        sel;
    logic        act_d;
    logic        act_fall;
    logic [2:0]  state_bits;

    assign req_edge   = req_s2 & ~req_d;
    assign fs         = n_int & ~n_int_next;
    assign fetch      = bus.m1 && bus.memreq && (bus.a == 16'h0066);
    assign sel        = bus.ioreq && bus.rd && (bus.a == STATUS_PORT);
    assign act_fall   = act_d & ~d_out_active;
    assign state_bits = state;
    assign busy       = (state != S_IDLE);
    assign d_out      = {err, busy, state_bits, grant};

    // Two-flop synchroniser plus the edge-detect delay register per request bit.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            req_s1 <= 3'b000;
            req_s2 <= 3'b000;
            req_d  <= 3'b000;
        end else begin
            req_s1 <= req;
            req_s2 <= req_s1;
            req_d  <= req_s2;
        end
    end

    // Next-state, grant and NMI logic; pending updates with new edges taking priority over clears.
    always_comb begin
        state_n  = state;
        grant_n  = grant;
        ptr_n    = ptr;
        n_nmi_n  = n_nmi;
        tcount_n = tcount;
        fcount_n = fcount;
        clr_mask = 3'b000;
        set_back = 3'b000;
        err_set  = 1'b0;
        win      = rr_pick(pending, ptr);
        win_oh   = 3'b001 << win;

        case (state)
            S_IDLE: begin
                if (pending != 3'b000)
                    state_n = S_ARM;
            end
            S_ARM: begin
                if (fs) begin
                    if (pending == 3'b000) begin
                        state_n = S_IDLE;
                    end else begin
                        grant_n  = win_oh;
                        clr_mask = win_oh;
                        ptr_n    = next_ptr(win);
                        n_nmi_n  = 1'b0;
                        tcount_n = 16'd0;
                        state_n  = S_ASSERT;
                    end
                end
            end
            S_ASSERT: begin
                if (fetch) begin
                    n_nmi_n = 1'b1;
                    state_n = S_SERVICE;
                end else if (tcount == TIMEOUT - 16'd1) begin
                    // CPU never took the NMI: release the line and requeue the source.
                    n_nmi_n  = 1'b1;
                    grant_n  = 3'b000;
                    err_set  = 1'b1;
                    set_back = grant;
                    state_n  = S_IDLE;
                end else begin
                    tcount_n = tcount + 16'd1;
                end
            end
            S_SERVICE: begin
                if (done) begin
                    grant_n  = 3'b000;
                    fcount_n = HOLDOFF_FRAMES;
                    state_n  = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (fcount == 8'd0) begin
                    state_n = S_IDLE;
                end else if (fs) begin
                    if (fcount == 8'd1) begin
                        fcount_n = 8'd0;
                        state_n  = S_IDLE;
                    end else begin
                        fcount_n = fcount - 8'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                grant_n = 3'b000;
                n_nmi_n = 1'b1;
            end
        endcase

        pending_n = (pending & ~clr_mask) | set_back | req_edge;

        if (err_set)
            err_n = 1'b1;
        else if (act_fall)
            err_n = 1'b0;
        else
            err_n = err;
    end

    // Arbiter state register; reset releases n_nmi and drops all pending requests.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pending <= 3'b000;
            ptr     <= 2'd0;
            grant   <= 3'b000;
            n_nmi   <= 1'b1;
            tcount  <= 16'd0;
            fcount  <= 8'd0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            ptr     <= ptr_n;
            grant   <= grant_n;
            n_nmi   <= n_nmi_n;
            tcount  <= tcount_n;
            fcount  <= fcount_n;
            err     <= err_n;
        end
    end

    // Status read strobe and its delayed copy used to clear err after a read completes.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            d_out_active <= 1'b0;
            act_d        <= 1'b0;
        end else begin
            d_out_active <= sel;
            act_d        <= d_out_active;
        end
    end

endmodule

// File: doc/nmi_arbiter.md
# nmi_arbiter

Shares the single Z80 NMI line between three requesters (magic button, pause button, divmmc NMI button) with rotating priority. It aligns every NMI assertion to the frame-interrupt edge, holds `n_nmi` low until the CPU fetches the NMI vector at 0x0066, then waits for the service handler to finish before re-arming. It sits between the synchronised button inputs and the CPU NMI pin, alongside the magic-mode logic, and exposes a status register on the I/O bus.

## Interface
Parameters:
- `TIMEOUT`, 16'd50000: clk28 cycles allowed in ASSERT before giving up.
- `HOLDOFF_FRAMES`, 2: frame strobes to wait after service before returning to IDLE.
- `STATUS_PORT`, 16'h00F7: full 16-bit I/O address of the status register.

Ports:
- `clk28`  input  1  system clock. One clock only.
- `rst`  input  1  asynchronous, active-high reset.
- `bus`  input  cpu_bus  CPU bus interface; uses `memreq`, `ioreq`, `rd`, `m1` and `a`.
- `n_int`  input  1  current frame interrupt.
- `n_int_next`  input  1  next-cycle frame interrupt.
- `req`  input  3  raw requests, active-high levels, asynchronous. Bit 0 is magic, bit 1 is pause, bit 2 is divmmc.
- `done`  input  1  one-cycle pulse, high when the NMI handler has finished.
- `n_nmi`  output  1  NMI to the CPU, active-low.
- `grant`  output  3  one-hot; identifies the source being serviced.
- `busy`  output  1  high whenever the state is not IDLE.
- `d_out`  output  8  status read data.
- `d_out_active`  output  1  status read strobe.

## Operation
- Input path: each `req` bit goes through a 2-flop synchroniser, then a rising-edge detector.
  - A detected edge sets `pending[i]`.
  - Held levels do not re-trigger; only a new edge sets `pending[i]` again.
- Frame strobe: `fs = n_int & ~n_int_next`.
- States:
  - IDLE: go to ARM when `pending != 0`.
  - ARM: on `fs`, pick the winner by round-robin starting at `ptr`. Set `grant` to the winner, clear its `pending` bit, set `ptr = winner+1` (mod 3), drive `n_nmi` low, go to ASSERT.
  - ASSERT:
    - On `bus.m1 && bus.memreq && bus.a == 16'h0066`: `n_nmi` goes high, go to SERVICE.
    - If instead the cycle counter reaches `TIMEOUT`: `n_nmi` goes high, `grant` = 0, set sticky `err`, re-set the winner's `pending` bit, go to IDLE.
  - SERVICE: hold `grant`. On `done`: `grant` = 0, load the frame counter with `HOLDOFF_FRAMES`, go to HOLDOFF.
  - HOLDOFF: decrement the counter on each `fs`; go to IDLE when it reaches 0. With `HOLDOFF_FRAMES=0`, go to IDLE the cycle after `done`.
- Arbitration boundaries:
  - A new edge on the same cycle as the clear of that `pending` bit wins, so the bit stays set.
  - Edges from any source during ASSERT, SERVICE or HOLDOFF are latched in `pending`, never lost.
  - `done` outside SERVICE is ignored.
- Status register:
  - Select: `bus.ioreq && bus.rd && bus.a == STATUS_PORT`.
  - `d_out = {err, busy, state[2:0], grant[2:0]}`, with state encoding IDLE=0, ARM=1, ASSERT=2, SERVICE=3, HOLDOFF=4.
  - `d_out_active` is the select registered once.
  - `err` clears on the falling edge of `d_out_active`.
- Reset values: `n_nmi`=1, `grant`=0, `busy`=0, `d_out_active`=0, `pending`=0, `ptr`=0, `err`=0, state IDLE, counters 0.
- Reset mid-operation: a reset in any state releases `n_nmi` immediately and discards all pending requests.

## Timing
- Edge-to-pending latency: 3 clk28 cycles (2 synchroniser flops plus the edge register).
- Grant timing: `grant` and the falling edge of `n_nmi` are registered on the clock edge where `fs` is sampled high in ARM, so they are visible 1 cycle after `fs`.
- NMI release: `n_nmi` rises 1 cycle after the vector fetch at 0x0066 is sampled; the fetch must not be delayed by the arbiter.
- Timeout: the ASSERT counter starts at 0 on entry and compares against `TIMEOUT-1`; the timeout exit takes effect on the following edge.
- `d_out` is combinational from registered state. `d_out_active` lags the bus select by 1 cycle.
- At most one NMI per frame, and at least `HOLDOFF_FRAMES` frames between the end of one service and the next assertion.

## Test plan
- Single request: pulse `req[0]`, then `fs`, then fetch 0x0066, then `done` → `grant`=3'b001; `n_nmi` low for exactly the span from `fs`+1 to fetch+1; state returns to IDLE after 2 more `fs`.
- Simultaneous requests: `req`=3'b111 edges in the same cycle with `ptr`=0 → grants in order 001, 010, 100, one per service cycle; `ptr` ends at 0.
- Timeout: grant `req[1]` and suppress the 0x0066 fetch for 50000 cycles → `n_nmi` high, `err`=1, `pending[1]` re-set; a status read returns bit7=1, and a second read returns bit7=0.
- Latching during service: `req[2]` edge during SERVICE of source 0 → after `done` and holdoff, source 2 is granted at the next `fs`; a held `req[2]` level produces no second grant.
- Status read: I/O read of 0x00F7 while in SERVICE with `grant` 010 → `d_out`=8'h5A; `d_out_active` is high 1 cycle after the select.
- Async reset: assert `rst` mid-ASSERT → `n_nmi`=1, `grant`=0, `busy`=0 immediately, without waiting for a clock edge.
